plru_repl_ctrl: RTL and testbench

- Per-set tree-PLRU replacement controller for set-associative caches (I$/D$ refill path).
- Holds one heap-indexed tree of WAY_CNT-1 bits per set.
- Applies hit "touch" updates, answers victim requests with a latched valid/ready handshake, commits the fill on handshake, and runs a sequenced per-set flush.

---
 rtl/plru_repl_ctrl_if.sv | 34 +++
 rtl/plru_repl_ctrl.sv | 155 +++++++++++++++
 tb/tb_plru_repl_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plru_repl_ctrl_if.sv
// Bus bundle between a cache refill path and its tree-PLRU replacement controller.
// master = cache side, slave = replacement controller.
interface plru_repl_ctrl_if #(
  parameter int WAY_CNT = 4,
  parameter int SET_CNT = 64
);
  localparam int SET_W = $clog2(SET_CNT);

  logic               touch_valid_i;
  logic [SET_W-1:0]   touch_set_i;
  logic [WAY_CNT-1:0] touch_way_i;
  logic               vreq_valid_i;
  logic               vreq_ready_o;
  logic [SET_W-1:0]   vreq_set_i;
  logic [WAY_CNT-1:0] vreq_inv_i;
  logic               victim_valid_o;
  logic               victim_ready_i;
  logic [WAY_CNT-1:0] victim_way_o;
  logic               flush_i;
  logic               flush_busy_o;
  logic               flush_done_o;

  modport master (
    output touch_valid_i, touch_set_i, touch_way_i,
    output vreq_valid_i, vreq_set_i, vreq_inv_i, victim_ready_i, flush_i,
    input  vreq_ready_o, victim_valid_o, victim_way_o, flush_busy_o, flush_done_o
  );

  modport slave (
    input  touch_valid_i, touch_set_i, touch_way_i,
    input  vreq_valid_i, vreq_set_i, vreq_inv_i, victim_ready_i, flush_i,
    output vreq_ready_o, victim_valid_o, victim_way_o, flush_busy_o, flush_done_o
  );
endinterface

// File: rtl/plru_repl_ctrl.sv
// Per-set tree-PLRU replacement controller: hit touches, one outstanding victim
// request with fill commit on handshake, and a sequenced one-set-per-cycle flush.
module plru_repl_ctrl #(
  parameter int WAY_CNT = 4,
  parameter int SET_CNT = 64,
  localparam int SET_W  = $clog2(SET_CNT)
) (
  input logic             clk,
  input logic             rst_n,
  plru_repl_ctrl_if.slave bus
);
  localparam int LVL = $clog2(WAY_CNT);

  typedef logic [WAY_CNT-1:1] tree_t;  // heap-indexed, node 1 is the root
  typedef logic [WAY_CNT-1:0] way_t;
  typedef enum logic {IDLE, FLUSH} state_e;

  // Marks every node on the touched way's path as pointing away from it.
  function automatic tree_t touch_tree(input tree_t t, input way_t way);
    tree_t r    = t;
    int    idx  = 0;
    int    node = 1;
    int    b;
    if (way == '0) return t;
    for (int i = 0; i < WAY_CNT; i++) if (way[i]) idx = i;
    for (int l = LVL - 1; l >= 0; l--) begin
      b       = (idx >> l) & 1;
      r[node] = (b == 0);
      node    = 2 * node + b;
    end
    return r;
  endfunction

  function automatic way_t plru_walk(input tree_t t);
    way_t v    = '0;
    int   node = 1;
    for (int l = 0; l < LVL; l++) node = 2 * node + (t[node] ? 1 : 0);
    v[node - WAY_CNT] = 1'b1;
    return v;
  endfunction

  function automatic way_t lowest_way(input way_t inv);
    way_t v = '0;
    for (int i = WAY_CNT - 1; i >= 0; i--) begin
      if (inv[i]) begin
        v    = '0;
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  state_e           state_q, state_d;
  tree_t            tree_q [SET_CNT];
  tree_t            tree_d [SET_CNT];
  logic             victim_valid_q, victim_valid_d;
  way_t             victim_way_q, victim_way_d;
  logic [SET_W-1:0] vset_q, vset_d;
  logic             flush_pend_q, flush_pend_d;
  logic [SET_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flush_done_q, flush_done_d;
  logic             flush_busy_q, flush_busy_d;
  logic             touch_en;
  logic             vreq_fire;
  tree_t            sel_tree;

  assign bus.vreq_ready_o   = (state_q == IDLE) && !victim_valid_q && !flush_pend_q;
  assign bus.victim_valid_o = victim_valid_q;
  assign bus.victim_way_o   = victim_way_q;
  assign bus.flush_busy_o   = flush_busy_q;
  assign bus.flush_done_o   = flush_done_q;

  assign touch_en  = (state_q == IDLE) && bus.touch_valid_i && (bus.touch_way_i != '0);
  assign vreq_fire = bus.vreq_valid_i && bus.vreq_ready_o;

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d        = state_q;
    tree_d         = tree_q;
    victim_valid_d = victim_valid_q;
    victim_way_d   = victim_way_q;
    vset_d         = vset_q;
    flush_pend_d   = flush_pend_q | bus.flush_i;
    flush_cnt_d    = flush_cnt_q;
    flush_done_d   = 1'b0;
    sel_tree       = tree_q[bus.vreq_set_i];

    if (touch_en) begin
      tree_d[bus.touch_set_i] = touch_tree(tree_q[bus.touch_set_i], bus.touch_way_i);
      if (bus.touch_set_i == bus.vreq_set_i) sel_tree = touch_tree(sel_tree, bus.touch_way_i);
    end

    // Fill commit lands on top of any same-cycle touch so the filled way ends most-recent.
    if (victim_valid_q && bus.victim_ready_i) begin
      tree_d[vset_q] = touch_tree(tree_d[vset_q], victim_way_q);
      victim_valid_d = 1'b0;
    end

    if (vreq_fire) begin
      victim_valid_d = 1'b1;
      vset_d         = bus.vreq_set_i;
      victim_way_d   = (bus.vreq_inv_i != '0) ? lowest_way(bus.vreq_inv_i) : plru_walk(sel_tree);
    end

    unique case (state_q)
      IDLE: begin
        if (flush_pend_q && !victim_valid_q) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        tree_d[flush_cnt_q] = '0;
        flush_cnt_d         = flush_cnt_q + SET_W'(1);
        if (flush_cnt_q == SET_W'(SET_CNT - 1)) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
          flush_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    flush_busy_d = (state_d == FLUSH);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      // NOTE: the tree array is deliberately reset; replacement order after reset must start from all-zero trees.
      tree_q         <= '{default: '0};
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      vset_q         <= '0;
      flush_pend_q   <= 1'b0;
      flush_cnt_q    <= '0;
      flush_done_q   <= 1'b0;
      flush_busy_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      tree_q         <= tree_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
      vset_q         <= vset_d;
      flush_pend_q   <= flush_pend_d;
      flush_cnt_q    <= flush_cnt_d;
      flush_done_q   <= flush_done_d;
      flush_busy_q   <= flush_busy_d;
    end
  end

  a_touch_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    bus.touch_valid_i |-> $onehot0(bus.touch_way_i));
endmodule

// File: tb/tb_plru_repl_ctrl.sv
// Scoreboard bench for plru_repl_ctrl: an ancestor-walk tree model predicts each
// victim at request time; predictions are popped and compared at the handshake.
module tb_plru_repl_ctrl;
  localparam int WAY_CNT = 4;
  localparam int SET_CNT = 64;
  localparam int SET_W   = $clog2(SET_CNT);

  typedef logic [WAY_CNT-1:0] way_t;
  typedef struct {
    int   set;
    way_t way;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  plru_repl_ctrl_if #(.WAY_CNT(WAY_CNT), .SET_CNT(SET_CNT)) bus();
  plru_repl_ctrl #(.WAY_CNT(WAY_CNT), .SET_CNT(SET_CNT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  logic mtree [SET_CNT][2*WAY_CNT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model: leaf of way w is node WAY_CNT+w; each ancestor points away from the child it came from.
  task automatic m_reset();
    for (int s = 0; s < SET_CNT; s++)
      for (int n = 0; n < 2 * WAY_CNT; n++) mtree[s][n] = 1'b0;
  endtask

  function automatic int way_idx(input way_t oh);
    int r = 0;
    for (int i = 0; i < WAY_CNT; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic way_t onehot(input int i);
    way_t r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic m_touch(input int s, input way_t oh);
    int n;
    if (oh == '0) return;
    n = WAY_CNT + way_idx(oh);
    while (n > 1) begin
      mtree[s][n >> 1] = (n % 2 == 0);
      n = n >> 1;
    end
  endtask

  function automatic way_t m_victim(input int s, input way_t inv);
    int n = 1;
    if (inv != '0) begin
      for (int i = 0; i < WAY_CNT; i++) if (inv[i]) return onehot(i);
    end
    while (n < WAY_CNT) n = 2 * n + (mtree[s][n] ? 1 : 0);
    return onehot(n - WAY_CNT);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.touch_valid_i  = 1'b0;
    bus.touch_set_i    = '0;
    bus.touch_way_i    = '0;
    bus.vreq_valid_i   = 1'b0;
    bus.vreq_set_i     = '0;
    bus.vreq_inv_i     = '0;
    bus.victim_ready_i = 1'b0;
    bus.flush_i        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    m_reset();
    exp_q.delete();
  endtask

  task automatic touch(input int set, input way_t way);
    bus.touch_valid_i = 1'b1;
    bus.touch_set_i   = SET_W'(set);
    bus.touch_way_i   = way;
    m_touch(set, way);
    step();
    bus.touch_valid_i = 1'b0;
    bus.touch_way_i   = '0;
  endtask

  // Issues a request (optionally with a same-cycle touch of the same set) and queues the prediction.
  task automatic request(input int set, input way_t inv, input way_t tway);
    bit   ok = 1'b0;
    exp_t e;
    for (int i = 0; i < 100; i++) begin
      if (bus.vreq_ready_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      check("vreq_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.vreq_valid_i = 1'b1;
    bus.vreq_set_i   = SET_W'(set);
    bus.vreq_inv_i   = inv;
    if (tway != '0) begin
      bus.touch_valid_i = 1'b1;
      bus.touch_set_i   = SET_W'(set);
      bus.touch_way_i   = tway;
      m_touch(set, tway);
    end
    e.set = set;
    e.way = m_victim(set, inv);
    exp_q.push_back(e);
    step();
    bus.vreq_valid_i  = 1'b0;
    bus.vreq_inv_i    = '0;
    bus.touch_valid_i = 1'b0;
    bus.touch_way_i   = '0;
    check("victim_valid_next_cycle", 32'(bus.victim_valid_o), 32'd1);
  endtask

  // Holds ready low for `hold` cycles (touching the latched set with hold_tway), then takes the victim.
  task automatic take(input int hold, input way_t hold_tway, input int c_set, input way_t c_tway);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q[0];
    for (int i = 0; i < hold; i++) begin
      if (hold_tway != '0) begin
        bus.touch_valid_i = 1'b1;
        bus.touch_set_i   = SET_W'(e.set);
        bus.touch_way_i   = hold_tway;
        m_touch(e.set, hold_tway);
      end
      step();
      bus.touch_valid_i = 1'b0;
      bus.touch_way_i   = '0;
      check("hold_victim_valid", 32'(bus.victim_valid_o), 32'd1);
      check("hold_victim_way", 32'(bus.victim_way_o), 32'(e.way));
      check("hold_vreq_ready", 32'(bus.vreq_ready_o), 32'd0);
    end
    e = exp_q.pop_front();
    check("victim_way", 32'(bus.victim_way_o), 32'(e.way));
    bus.victim_ready_i = 1'b1;
    if (c_tway != '0) begin
      bus.touch_valid_i = 1'b1;
      bus.touch_set_i   = SET_W'(c_set);
      bus.touch_way_i   = c_tway;
      m_touch(c_set, c_tway);
    end
    m_touch(e.set, e.way);
    step();
    bus.victim_ready_i = 1'b0;
    bus.touch_valid_i  = 1'b0;
    bus.touch_way_i    = '0;
    check("victim_valid_cleared", 32'(bus.victim_valid_o), 32'd0);
  endtask

  task automatic watch_flush(input int cycles, input int inject_at, output int busy_cnt,
                             output int done_cnt, output int ready_in_busy);
    busy_cnt      = 0;
    done_cnt      = 0;
    ready_in_busy = 0;
    for (int i = 0; i < cycles; i++) begin
      if (i == inject_at) begin
        bus.flush_i       = 1'b1;
        bus.touch_valid_i = 1'b1;
        bus.touch_set_i   = '0;
        bus.touch_way_i   = 4'b0001;
      end
      step();
      bus.flush_i       = 1'b0;
      bus.touch_valid_i = 1'b0;
      bus.touch_way_i   = '0;
      if (bus.flush_busy_o) busy_cnt++;
      if (bus.flush_busy_o && bus.vreq_ready_o) ready_in_busy++;
      if (bus.flush_done_o) begin
        done_cnt++;
        check("busy_low_at_done", 32'(bus.flush_busy_o), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int busy_cnt, done_cnt, ready_in_busy;

    // Reset defaults and first fill.
    do_reset();
    check("rst_victim_valid", 32'(bus.victim_valid_o), 32'd0);
    check("rst_victim_way", 32'(bus.victim_way_o), 32'd0);
    check("rst_flush_busy", 32'(bus.flush_busy_o), 32'd0);
    check("rst_flush_done", 32'(bus.flush_done_o), 32'd0);
    check("rst_vreq_ready", 32'(bus.vreq_ready_o), 32'd1);
    request(5, '0, '0);
    take(0, '0, 0, '0);
    request(5, '0, '0);
    take(0, '0, 0, '0);

    // PLRU walk after two touches.
    do_reset();
    touch(5, 4'b0001);
    touch(5, 4'b0100);
    request(5, '0, '0);
    take(0, '0, 0, '0);

    // Invalid-way preference, including the top way and all-invalid.
    request(9, 4'b1010, '0);
    take(0, '0, 0, '0);
    request(9, 4'b1000, '0);
    take(0, '0, 0, '0);
    request(9, 4'b1111, '0);
    take(0, '0, 0, '0);

    // Same-cycle touch bypass, and a zero touch that must be a no-op.
    do_reset();
    request(3, '0, 4'b0001);
    take(0, '0, 0, '0);
    touch(4, 4'b0000);
    request(4, '0, '0);
    take(0, '0, 0, '0);

    // Backpressure with touches to the latched set.
    request(7, '0, '0);
    take(3, 4'b1000, 0, '0);
    request(7, '0, '0);
    take(0, '0, 0, '0);

    // Touch and commit on the same set, then on different sets.
    request(10, '0, '0);
    take(0, '0, 10, 4'b0100);
    request(10, '0, '0);
    take(0, '0, 0, '0);
    request(11, '0, '0);
    take(0, '0, 12, 4'b0001);
    request(12, '0, '0);
    take(0, '0, 0, '0);
    request(11, '0, '0);
    take(0, '0, 0, '0);

    // Flush requested with a victim outstanding waits for the handshake.
    request(5, '0, '0);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("flush_wait_busy", 32'(bus.flush_busy_o), 32'd0);
      check("flush_wait_ready", 32'(bus.vreq_ready_o), 32'd0);
      step();
    end
    take(0, '0, 0, '0);
    watch_flush(80, 10, busy_cnt, done_cnt, ready_in_busy);
    m_reset();
    check("flush_busy_cycles", 32'(busy_cnt), 32'd64);
    check("flush_done_pulses", 32'(done_cnt), 32'd1);
    check("flush_ready_in_busy", 32'(ready_in_busy), 32'd0);
    request(5, '0, '0);
    take(0, '0, 0, '0);
    request(0, '0, '0);
    take(0, '0, 0, '0);

    // Reset asserted mid-flush.
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    repeat (20) step();
    check("midflush_busy", 32'(bus.flush_busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_midflush_busy", 32'(bus.flush_busy_o), 32'd0);
    check("rst_midflush_done", 32'(bus.flush_done_o), 32'd0);
    check("rst_midflush_ready", 32'(bus.vreq_ready_o), 32'd1);
    step();
    rst_n = 1'b1;
    m_reset();
    watch_flush(80, -1, busy_cnt, done_cnt, ready_in_busy);
    check("post_rst_busy_cycles", 32'(busy_cnt), 32'd0);
    check("post_rst_done_pulses", 32'(done_cnt), 32'd0);

    // Reset with a victim outstanding.
    request(21, '0, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("rst_outstanding_valid", 32'(bus.victim_valid_o), 32'd0);
    check("rst_outstanding_way", 32'(bus.victim_way_o), 32'd0);
    step();
    rst_n = 1'b1;
    exp_q.delete();
    m_reset();
    step();
    request(21, '0, '0);
    take(0, '0, 0, '0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
